// File: rtl/cmac_int8_accu.sv
// ---------------------------------------------------------------------------
// cmac_int8_accu
//
// Purpose:
//   Takes beats of eight signed 16-bit products from the int8 multiplier
//   array. It reduces each beat through a two-stage registered adder tree.
//   It then accumulates the beat sums over a group of beats, where in_last
//   marks the final beat of the group. Each group yields one saturated
//   signed result, a sticky saturation flag and a saturating beat count.
//   The result is delivered over a valid/ready handshake.
//
// Ports:
//   nvdla_core_clk  in   clock, rising edge
//   nvdla_core_rst  in   synchronous active-high reset
//   in_valid        in   beat valid
//   in_ready        out  beat accepted when in_valid & in_ready
//   in_prod[127:0]  in   8 lanes of signed 16-bit products, lane i at [16i+:16]
//   in_mask[7:0]    in   per-lane enable; a disabled lane contributes zero
//   in_last         in   final beat of the group
//   out_valid       out  result valid
//   out_ready       in   result consumed when out_valid & out_ready
//   out_sum         out  saturated signed group sum, ACC_W bits
//   out_sat         out  saturation happened somewhere in the group
//   out_beats       out  beats in the group, saturating at all-ones
// ---------------------------------------------------------------------------
module cmac_int8_accu #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_prod,
  input  logic [7:0]         in_mask,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic               out_sat,
  output logic [CNT_W-1:0]   out_beats
);

  // One extra bit holds any base + beat sum without wrapping, because the
  // beat sum (19 bits) is never wider than the accumulator (ACC_W >= 20).
  localparam int TW = ACC_W + 1;

  localparam logic signed [TW-1:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [TW-1:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]     CNT_MAX = {CNT_W{1'b1}};

  // Pipeline and accumulator state
  logic                     s1_valid;
  logic                     s1_last;
  logic signed [16:0]       s1_sum [4];
  logic                     s2_valid;
  logic                     s2_last;
  logic signed [18:0]       s2_sum;
  logic signed [ACC_W-1:0]  acc;
  logic                     acc_sat;
  logic [CNT_W-1:0]         acc_cnt;
  logic                     group_start;

  // Combinational helpers
  logic                     stall;
  logic                     accept;
  logic signed [15:0]       lane [8];
  logic signed [16:0]       pair_sum [4];
  logic signed [18:0]       tree_sum;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [TW-1:0]     acc_t;
  logic signed [ACC_W-1:0]  acc_clamped;
  logic                     ovf;
  logic                     sat_next;
  logic [CNT_W-1:0]         cnt_next;

  // A result that is waiting for a consumer freezes the whole datapath.
  // Reset also closes the input, so nothing is taken while it is held.
  always_comb begin
    stall    = out_valid & ~out_ready;
    in_ready = ~stall & ~nvdla_core_rst;
    accept   = in_valid & in_ready;
  end

  // Lane masking and the first level of the tree: pairwise sums,
  // each sign-extended by one bit so that the sum cannot wrap.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lane[i] = in_mask[i] ? $signed(in_prod[16*i +: 16]) : 16'sd0;
    end
    for (int j = 0; j < 4; j++) begin
      pair_sum[j] = {lane[2*j][15], lane[2*j]} + {lane[2*j+1][15], lane[2*j+1]};
    end
  end

  // Second level of the tree. Four 17-bit values need at most 19 bits.
  always_comb begin
    tree_sum = {{2{s1_sum[0][16]}}, s1_sum[0]} + {{2{s1_sum[1][16]}}, s1_sum[1]}
             + {{2{s1_sum[2][16]}}, s1_sum[2]} + {{2{s1_sum[3][16]}}, s1_sum[3]};
  end

  // Accumulate step. A group's first beat starts from zero, not from acc.
  // Sat and the count are also rebased at that point, so the group-start
  // flag alone separates groups.
  always_comb begin
    acc_base    = group_start ? '0 : acc;
    acc_t       = {acc_base[ACC_W-1], acc_base} + {{(TW-19){s2_sum[18]}}, s2_sum};
    ovf         = 1'b0;
    acc_clamped = acc_t[ACC_W-1:0];
    if (acc_t > ACC_MAX) begin
      acc_clamped = ACC_MAX[ACC_W-1:0];
      ovf         = 1'b1;
    end else if (acc_t < ACC_MIN) begin
      acc_clamped = ACC_MIN[ACC_W-1:0];
      ovf         = 1'b1;
    end
    sat_next = (group_start ? 1'b0 : acc_sat) | ovf;
    if (group_start) begin
      cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (acc_cnt == CNT_MAX) begin
      cnt_next = CNT_MAX;
    end else begin
      cnt_next = acc_cnt + 1'b1;
    end
  end

  // All state. Everything holds during a stall. Otherwise the valids
  // advance one stage per cycle. The output register either reloads with
  // a new result or drops valid. With no stall, any held result is being
  // consumed in this same cycle.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      for (int j = 0; j < 4; j++) s1_sum[j] <= '0;
      s2_valid    <= 1'b0;
      s2_last     <= 1'b0;
      s2_sum      <= '0;
      acc         <= '0;
      acc_sat     <= 1'b0;
      acc_cnt     <= '0;
      group_start <= 1'b1;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_sat     <= 1'b0;
      out_beats   <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_last <= in_last;
        for (int j = 0; j < 4; j++) s1_sum[j] <= pair_sum[j];
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last <= s1_last;
        s2_sum  <= tree_sum;
      end

      out_valid <= s2_valid & s2_last;

      if (s2_valid) begin
        if (s2_last) begin
          out_sum     <= acc_clamped;
          out_sat     <= sat_next;
          out_beats   <= cnt_next;
          acc         <= '0;
          acc_sat     <= 1'b0;
          acc_cnt     <= '0;
          group_start <= 1'b1;
        end else begin
          acc         <= acc_clamped;
          acc_sat     <= sat_next;
          acc_cnt     <= cnt_next;
          group_start <= 1'b0;
        end
      end
    end
  end

endmodule
